quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 176 +++++++++++++++++
 tb/tb_quad_decoder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronised, glitch-filtered A/B/Z channels feeding a
// wrapping 16-bit position counter, index zeroing, sticky error flag and windowed speed.
module quad_decoder #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned WINDOW   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_z,
    input  logic        idx_en,
    input  logic        clr_err,
    output logic [15:0] pos,
    output logic        dir,
    output logic [15:0] speed,
    output logic        speed_valid,
    output logic        err
);
    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned WIN_W = $clog2(WINDOW);

    localparam logic signed [16:0] ACC_MAX = 17'sh0FFFF;
    localparam logic signed [16:0] ACC_MIN = 17'sh10000;
    localparam logic signed [15:0] SPD_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SPD_MIN = 16'sh8000;

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] filt;

    // two-flop synchronisers, bit order {z, b, a}
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_z, enc_b, enc_a};
            sync2 <= sync1;
        end
    end

    // per-channel filter: follow sync2 only after FILT_LEN consecutive differing samples
    for (genvar i = 0; i < 3; i++) begin : g_filt
        logic [CNT_W-1:0] cnt;
        logic             f_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                f_q <= 1'b0;
            end else if (sync2[i] != f_q) begin
                if (cnt == CNT_W'(FILT_LEN - 1)) begin
                    f_q <= sync2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign filt[i] = f_q;
    end

    logic [1:0]        ab;
    logic [1:0]        ab_prev;
    logic              z_prev;
    logic              init;
    logic              ab_chg;
    logic              illegal;
    logic              step_fwd;
    logic              step_rev;
    logic              z_rise;
    logic signed [1:0] step_val;

    // transition classification on the filtered {a, b} pair
    always_comb begin
        ab       = {filt[0], filt[1]};
        ab_chg   = (ab != ab_prev);
        illegal  = ab_chg && !init && (ab == ~ab_prev);
        step_fwd = ab_chg && !init && (ab == {~ab_prev[0], ab_prev[1]});
        step_rev = ab_chg && !init && (ab == {ab_prev[0], ~ab_prev[1]});
        z_rise   = filt[2] && !z_prev && idx_en;
        step_val = 2'sb00;
        if (step_fwd) begin
            step_val = 2'sb01;
        end else if (step_rev) begin
            step_val = 2'sb11;
        end
    end

    // position, direction and error state
    always_ff @(posedge clk) begin
        if (rst) begin
            ab_prev <= '0;
            z_prev  <= 1'b0;
            init    <= 1'b1;
            pos     <= '0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            ab_prev <= ab;
            z_prev  <= filt[2];
            if (ab_chg) begin
                init <= 1'b0;
            end
            if (z_rise) begin
                pos <= '0;
            end else if (step_fwd) begin
                pos <= pos + 16'd1;
            end else if (step_rev) begin
                pos <= pos - 16'd1;
            end
            if (step_fwd) begin
                dir <= 1'b1;
            end else if (step_rev) begin
                dir <= 1'b0;
            end
            if (illegal) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    logic [WIN_W-1:0]  win_cnt;
    logic signed [16:0] acc;
    logic signed [17:0] acc_wide;
    logic signed [16:0] acc_sum;
    logic signed [15:0] speed_sat;
    logic               win_end;

    // accumulator next value and saturated speed candidate
    always_comb begin
        win_end  = (win_cnt == WIN_W'(WINDOW - 1));
        acc_wide = 18'(acc) + 18'(step_val);
        if (acc_wide > 18'(ACC_MAX)) begin
            acc_sum = ACC_MAX;
        end else if (acc_wide < 18'(ACC_MIN)) begin
            acc_sum = ACC_MIN;
        end else begin
            acc_sum = 17'(acc_wide);
        end
        if (acc_sum > 17'(SPD_MAX)) begin
            speed_sat = SPD_MAX;
        end else if (acc_sum < 17'(SPD_MIN)) begin
            speed_sat = SPD_MIN;
        end else begin
            speed_sat = 16'(acc_sum);
        end
    end

    // free-running measurement window
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            acc         <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= win_end;
            if (win_end) begin
                win_cnt <= '0;
                acc     <= '0;
                speed   <= speed_sat;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                acc     <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: per-cycle reference model plus hand-computed
// checkpoints for latency, filtering, wrap, error, speed, index and reset.
module tb_quad_decoder;
    localparam int FL = 3;
    localparam int W  = 100;

    logic        clk = 1'b0;
    logic        rst, enc_a, enc_b, enc_z, idx_en, clr_err;
    logic [15:0] pos, speed;
    logic        dir, speed_valid, err;

    logic        w_rst, w_a, w_b;
    logic [15:0] w_pos, w_speed;
    logic        w_dir, w_sv, w_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int cur_idx, w_idx;
    int sv_cyc[$];
    int sv_spd[$];

    quad_decoder #(.FILT_LEN(FL), .WINDOW(W)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .idx_en(idx_en), .clr_err(clr_err), .pos(pos), .dir(dir),
        .speed(speed), .speed_valid(speed_valid), .err(err)
    );

    quad_decoder #(.FILT_LEN(1), .WINDOW(50000)) dut_w (
        .clk(clk), .rst(w_rst), .enc_a(w_a), .enc_b(w_b), .enc_z(1'b0),
        .idx_en(1'b0), .clr_err(1'b0), .pos(w_pos), .dir(w_dir),
        .speed(w_speed), .speed_valid(w_sv), .err(w_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (speed_valid === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_spd.push_back(int'($signed(speed)));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // quadrature phase index of an {a, b} pair: forward motion increments it mod 4
    function automatic int gidx(input bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int wrap16(input int x);
        int m;
        m = ((x % 65536) + 65536) % 65536;
        return (m > 32767) ? m - 65536 : m;
    endfunction

    function automatic int sat16(input int x);
        return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
    endfunction

    // reference model, advanced once per rising edge and compared with the DUT
    bit [2:0] m_s1, m_s2, m_f;
    bit [2:0] m_hist [FL];
    bit [1:0] m_ab_seen;
    bit       m_z_seen, m_init, m_dir, m_err, m_sv, m_valid = 1'b0;
    int       m_pos, m_acc, m_speed, m_cyc;

    always @(posedge clk) begin : model
        bit       r_rst, r_idx, r_clr, ill, zr, all_diff;
        bit [2:0] r_raw;
        bit [1:0] ab_new;
        int       step;
        r_rst = rst;
        r_idx = idx_en;
        r_clr = clr_err;
        r_raw = {enc_z, enc_b, enc_a};
        #1;
        if (r_rst) begin
            m_s1 = '0; m_s2 = '0; m_f = '0;
            for (int k = 0; k < FL; k++) m_hist[k] = '0;
            m_ab_seen = '0; m_z_seen = 1'b0; m_init = 1'b1;
            m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
            m_acc = 0; m_speed = 0; m_sv = 1'b0; m_cyc = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            step = 0;
            ill  = 1'b0;
            ab_new = {m_f[0], m_f[1]};
            if (ab_new != m_ab_seen) begin
                if (m_init) begin
                    m_init = 1'b0;
                end else begin
                    case ((gidx(ab_new) - gidx(m_ab_seen) + 4) % 4)
                        1:       step = 1;
                        3:       step = -1;
                        default: ill = 1'b1;
                    endcase
                end
            end
            m_ab_seen = ab_new;
            zr = m_f[2] && !m_z_seen && r_idx;
            m_z_seen = m_f[2];
            m_pos = zr ? 0 : wrap16(m_pos + step);
            if (step == 1) m_dir = 1'b1;
            else if (step == -1) m_dir = 1'b0;
            if (ill) m_err = 1'b1;
            else if (r_clr) m_err = 1'b0;
            m_acc += step;
            m_sv = 1'b0;
            if (m_cyc % W == W - 1) begin
                m_speed = sat16(m_acc);
                m_acc = 0;
                m_sv = 1'b1;
            end
            m_cyc++;
            for (int k = FL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            for (int i = 0; i < 3; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < FL; k++) if (m_hist[k][i] == m_f[i]) all_diff = 1'b0;
                if (all_diff) m_f[i] = ~m_f[i];
            end
            m_s2 = m_s1;
            m_s1 = r_raw;
        end
        if (m_valid) begin
            tests_run++;
            if (pos !== 16'(m_pos) || dir !== m_dir || err !== m_err ||
                speed !== 16'(m_speed) || speed_valid !== m_sv) begin
                tests_failed++;
                $display("FAIL model_cycle %0d: pos %0d/%0d dir %b/%b err %b/%b speed %0d/%0d sv %b/%b (got/want)",
                         cyc, $signed(pos), m_pos, dir, m_dir, err, m_err,
                         $signed(speed), m_speed, speed_valid, m_sv);
            end
        end
    end

    task automatic set_ab(input int idx);
        enc_a = (idx == 1 || idx == 2);
        enc_b = (idx == 2 || idx == 3);
    endtask

    task automatic set_w(input int idx);
        w_a = (idx == 1 || idx == 2);
        w_b = (idx == 2 || idx == 3);
    endtask

    // one forward step, holding the phase 10 clk and measuring edges until pos moves
    task automatic step_fwd_meas();
        logic [15:0] p0;
        int lat;
        p0 = pos;
        lat = -1;
        cur_idx = (cur_idx + 1) % 4;
        set_ab(cur_idx);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (lat < 0 && pos !== p0) lat = k;
        end
        check("step_latency", lat, 6);
    endtask

    task automatic run_steps(input int dirn, input int n, input int period);
        for (int k = 0; k < n; k++) begin
            cur_idx = (cur_idx + dirn + 4) % 4;
            set_ab(cur_idx);
            repeat (period) @(negedge clk);
        end
    endtask

    // pulse enc_a for len cycles; report first edge and count of edges where pos moved
    task automatic pulse_a(input int len, output int first, output int n_moved, output int moved_val);
        logic [15:0] p0;
        p0 = pos;
        first = -1;
        n_moved = 0;
        moved_val = int'($signed(p0));
        enc_a = ~enc_a;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == len) enc_a = ~enc_a;
            if (pos !== p0) begin
                n_moved++;
                if (first < 0) begin
                    first = k;
                    moved_val = int'($signed(pos));
                end
            end
        end
    endtask

    task automatic illegal_toggle();
        cur_idx = (cur_idx + 2) % 4;
        set_ab(cur_idx);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int first, n_moved, mv, n, lat;
        rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        idx_en = 1'b0; clr_err = 1'b0;
        w_rst = 1'b1; w_a = 1'b0; w_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pos", int'($signed(pos)), 0);
        check("reset_speed", int'($signed(speed)), 0);
        check("reset_dir_err_sv", {dir, err, speed_valid}, 0);
        rst = 1'b0;
        w_rst = 1'b0;

        // first non-zero filtered value only seeds the decoder
        cur_idx = 3;
        set_ab(cur_idx);
        repeat (10) @(negedge clk);
        check("init_no_step", int'($signed(pos)), 0);
        check("init_no_err", err, 0);

        for (int s = 0; s < 32; s++) step_fwd_meas();
        check("fwd_pos", int'($signed(pos)), 32);
        check("fwd_dir", dir, 1);
        check("fwd_err", err, 0);

        pulse_a(2, first, n_moved, mv);
        check("glitch2_moves", n_moved, 0);
        pulse_a(3, first, n_moved, mv);
        check("pulse3_first_edge", first, 6);
        check("pulse3_value", mv, 31);
        check("pulse3_width", n_moved, 3);
        check("pulse3_back", int'($signed(pos)), 32);

        illegal_toggle();
        repeat (10) @(negedge clk);
        check("illegal_err", err, 1);
        check("illegal_pos", int'($signed(pos)), 32);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", err, 0);
        // illegal transition lands on edge 6; clr_err is held across that edge
        illegal_toggle();
        repeat (5) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("illegal_vs_clr_from0", err, 1);
        repeat (5) @(negedge clk);
        illegal_toggle();
        repeat (5) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("illegal_vs_clr_from1", err, 1);
        repeat (4) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_again", err, 0);
        check("err_pos_kept", int'($signed(pos)), 32);

        sv_cyc.delete(); sv_spd.delete();
        run_steps(1, 100, 4);
        n = sv_cyc.size();
        check("fwd_sv_count_ge2", int'(n >= 2), 1);
        if (n >= 2) begin
            check("fwd_speed_a", sv_spd[n-2], 25);
            check("fwd_speed_b", sv_spd[n-1], 25);
            check("fwd_sv_spacing", sv_cyc[n-1] - sv_cyc[n-2], 100);
        end
        sv_cyc.delete(); sv_spd.delete();
        run_steps(-1, 100, 4);
        n = sv_cyc.size();
        check("rev_sv_count_ge2", int'(n >= 2), 1);
        if (n >= 2) begin
            check("rev_speed_a", sv_spd[n-2], -25);
            check("rev_speed_b", sv_spd[n-1], -25);
            check("rev_sv_spacing", sv_cyc[n-1] - sv_cyc[n-2], 100);
        end
        repeat (10) @(negedge clk);
        check("speed_pos", int'($signed(pos)), 32);

        run_steps(1, 25, 4);
        repeat (10) @(negedge clk);
        check("idx_setup", int'($signed(pos)), 57);
        idx_en = 1'b0;
        cur_idx = (cur_idx + 1) % 4;
        set_ab(cur_idx);
        enc_z = 1'b1;
        repeat (10) @(negedge clk);
        enc_z = 1'b0;
        repeat (10) @(negedge clk);
        check("idx_off_pos", int'($signed(pos)), 58);
        run_steps(-1, 1, 10);
        check("idx_back_pos", int'($signed(pos)), 57);
        idx_en = 1'b1;
        cur_idx = (cur_idx + 1) % 4;
        set_ab(cur_idx);
        enc_z = 1'b1;
        repeat (10) @(negedge clk);
        check("idx_on_pos", int'($signed(pos)), 0);
        check("idx_on_dir", dir, 1);
        enc_z = 1'b0;
        repeat (10) @(negedge clk);
        idx_en = 1'b0;

        // reset in the middle of a window and of a filter run
        run_steps(1, 1, 10);
        check("pre_reset_pos", int'($signed(pos)), 1);
        cur_idx = (cur_idx + 1) % 4;
        set_ab(cur_idx);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_pos", int'($signed(pos)), 0);
        check("midreset_dir", dir, 0);
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (lat < 0 && speed_valid === 1'b1) lat = k;
        end
        check("first_sv_after_reset", lat, 100);
        check("post_reset_init_no_step", int'($signed(pos)), 0);

        // wrap on the fast-filter instance, one step per clock
        w_idx = 3;
        set_w(w_idx);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 32767; k++) begin
            w_idx = (w_idx + 1) % 4;
            set_w(w_idx);
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("wrap_max", int'($signed(w_pos)), 32767);
        w_idx = (w_idx + 1) % 4;
        set_w(w_idx);
        repeat (8) @(negedge clk);
        check("wrap_up", int'($signed(w_pos)), -32768);
        w_idx = (w_idx + 3) % 4;
        set_w(w_idx);
        repeat (8) @(negedge clk);
        check("wrap_down", int'($signed(w_pos)), 32767);
        check("wrap_dir", w_dir, 0);
        check("wrap_err", w_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
